// File: rtl/ocp_master_arbiter.sv
// ---------------------------------------------------------------------------
// ocp_master_arbiter
//
// Arbitrates two requesters onto a single OCP master bridge port. Only one
// transaction is in flight at a time. The winner's op/address/write data are
// latched in IDLE. They are presented to the bridge for exactly one ISSUE
// cycle. Completion (xfer_done) or a timeout is then awaited in WAIT, and the
// result is reported to the winner with a one-cycle done pulse in RESP.
//
// Requester handshake: a requester raises req_rd[i] and/or req_wr[i] and
// holds it until done[i] pulses. done[i] lasts one cycle. err and rdata are
// meaningful only while done is high. A request still asserted in the cycle
// after done is taken as a new request.
//
// Ports
//   Clk, reset          : clock, synchronous active-high reset
//   req_rd, req_wr      : per-requester read / write request (wr wins if both)
//   req_addr0/1         : requester addresses
//   req_wdata0/1        : requester write data
//   gnt                 : one-hot grant, held from ISSUE through RESP
//   done, err, rdata    : completion pulse, timeout flag, read data
//   address, write_data : bridge address / write data (latched values)
//   data_valid          : bridge write data valid (ISSUE, writes only)
//   read_request        : bridge read request (ISSUE only)
//   write_request       : bridge write request (ISSUE only)
//   read_data           : bridge read data
//   xfer_done           : bridge completion pulse (only honoured in WAIT)
//   o_dbg_state         : current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
// ---------------------------------------------------------------------------
module ocp_master_arbiter #(
  parameter int         MADDR_WIDTH = 64,
  parameter int         MDATA_WIDTH = 8,
  parameter logic [7:0] TIMEOUT     = 8'd255
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic [1:0]             req_rd,
  input  logic [1:0]             req_wr,
  input  logic [MADDR_WIDTH-1:0] req_addr0,
  input  logic [MADDR_WIDTH-1:0] req_addr1,
  input  logic [MDATA_WIDTH-1:0] req_wdata0,
  input  logic [MDATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic                   err,
  output logic [MDATA_WIDTH-1:0] rdata,
  output logic [MADDR_WIDTH-1:0] address,
  output logic [MDATA_WIDTH-1:0] write_data,
  output logic                   data_valid,
  output logic                   read_request,
  output logic                   write_request,
  input  logic [MDATA_WIDTH-1:0] read_data,
  input  logic                   xfer_done,
  output logic [1:0]             o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_gnt;
  logic                   r_win;
  logic                   r_last_gnt;
  logic                   r_is_wr;
  logic                   r_err;
  logic [7:0]             r_cnt;
  logic [MADDR_WIDTH-1:0] r_addr;
  logic [MDATA_WIDTH-1:0] r_wdata;
  logic [MDATA_WIDTH-1:0] r_rdata;

  logic [1:0]             w_active;
  logic                   w_winner;
  logic                   w_tmo_hit;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    w_active = req_rd | req_wr;
    w_winner = 1'b0;
    if (w_active == 2'b11) begin
      w_winner = ~r_last_gnt;
    end else begin
      w_winner = w_active[1];
    end
  end

  // Counter is cleared on entry to WAIT. The last WAIT cycle is therefore the
  // one in which it reads TIMEOUT-1, giving exactly TIMEOUT WAIT cycles.
  assign w_tmo_hit = ((r_cnt + 8'd1) == TIMEOUT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (|w_active) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (xfer_done || w_tmo_hit) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_gnt      <= 2'b00;
      r_win      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_is_wr    <= 1'b0;
      r_err      <= 1'b0;
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_active) begin
            r_win   <= w_winner;
            r_gnt   <= w_winner ? 2'b10 : 2'b01;
            // A requester raising both rd and wr gets a write.
            r_is_wr <= req_wr[w_winner];
            r_addr  <= w_winner ? req_addr1 : req_addr0;
            r_wdata <= w_winner ? req_wdata1 : req_wdata0;
            r_err   <= 1'b0;
          end
        end
        ST_ISSUE: begin
          r_cnt <= 8'd0;
        end
        ST_WAIT: begin
          // xfer_done takes priority over a coincident timeout.
          if (xfer_done) begin
            r_err <= 1'b0;
            if (!r_is_wr) begin
              r_rdata <= read_data;
            end
          end else if (w_tmo_hit) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          r_gnt      <= 2'b00;
          r_last_gnt <= r_win;
          r_err      <= 1'b0;
        end
        default: begin
          r_gnt <= 2'b00;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  assign gnt           = r_gnt;
  assign done          = (r_state == ST_RESP) ? r_gnt : 2'b00;
  assign err           = (r_state == ST_RESP) & r_err;
  assign rdata         = r_rdata;
  assign address       = r_addr;
  assign write_data    = r_wdata;
  assign read_request  = (r_state == ST_ISSUE) & ~r_is_wr;
  assign write_request = (r_state == ST_ISSUE) & r_is_wr;
  assign data_valid    = (r_state == ST_ISSUE) & r_is_wr;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ocp_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ocp_master_arbiter
//
// The driver applies requests and plays the OCP bridge. Expected bridge issue
// beats and expected completions are pushed to queues when a request is
// driven. A negedge monitor pops and compares them whenever the DUT shows a
// request beat or a done pulse.
// ---------------------------------------------------------------------------
module tb_ocp_master_arbiter;

  localparam int         AW  = 64;
  localparam int         DW  = 8;
  localparam logic [7:0] TMO = 8'd4;
  // issue entry: {wr_req, rd_req, data_valid, gnt[1:0], addr, wdata}
  localparam int         IW  = 5 + AW + DW;
  // completion entry: {is_read, done[1:0], err, rdata}
  localparam int         CW  = 4 + DW;

  logic          Clk = 1'b0;
  logic          reset;
  logic [1:0]    req_rd, req_wr;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    gnt, done;
  logic          err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic          data_valid, read_request, write_request;
  logic [DW-1:0] read_data;
  logic          xfer_done;
  logic [1:0]    o_dbg_state;

  ocp_master_arbiter #(
    .MADDR_WIDTH (AW),
    .MDATA_WIDTH (DW),
    .TIMEOUT     (TMO)
  ) dut (
    .Clk           (Clk),
    .reset         (reset),
    .req_rd        (req_rd),
    .req_wr        (req_wr),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_wdata0    (req_wdata0),
    .req_wdata1    (req_wdata1),
    .gnt           (gnt),
    .done          (done),
    .err           (err),
    .rdata         (rdata),
    .address       (address),
    .write_data    (write_data),
    .data_valid    (data_valid),
    .read_request  (read_request),
    .write_request (write_request),
    .read_data     (read_data),
    .xfer_done     (xfer_done),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------------------------------------------------------- clock/reset
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int            n_checks = 0;
  int            n_errors = 0;
  logic [IW-1:0] iss_q[$];
  logic [CW-1:0] exp_q[$];

  // bench model state
  logic [AW-1:0] m_a0, m_a1;
  logic [DW-1:0] m_d0, m_d1;
  logic          m_last;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  logic [IW-1:0] mon_ie;
  logic [CW-1:0] mon_ce;

  always @(negedge Clk) begin
    if (read_request || write_request) begin
      if (iss_q.size() == 0) begin
        check_eq("iss_unexp", {write_request, read_request}, 2'b00);
      end else begin
        mon_ie = iss_q.pop_front();
        check_eq("iss_wr",    write_request, mon_ie[IW-1]);
        check_eq("iss_rd",    read_request,  mon_ie[IW-2]);
        check_eq("iss_dv",    data_valid,    mon_ie[IW-3]);
        check_eq("iss_gnt",   gnt,           mon_ie[IW-4 -: 2]);
        check_eq("iss_addr",  address,       mon_ie[DW +: AW]);
        check_eq("iss_wdata", write_data,    mon_ie[DW-1:0]);
      end
    end
    if (data_valid && !write_request) check_eq("dv_stray", data_valid, 1'b0);
    if (done != 2'b00) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexp", done, 2'b00);
      end else begin
        mon_ce = exp_q.pop_front();
        check_eq("resp_done", done, mon_ce[CW-2 -: 2]);
        check_eq("resp_gnt",  gnt,  mon_ce[CW-2 -: 2]);
        check_eq("resp_err",  err,  mon_ce[DW]);
        if (mon_ce[CW-1]) check_eq("resp_rdata", rdata, mon_ce[DW-1:0]);
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Called just after a rising edge with the DUT in IDLE. xdelay selects the
  // WAIT cycle (0 = first) in which xfer_done pulses; negative = never.
  task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr, input int xdelay,
                         input logic [DW-1:0] rdv, input bit hold, input bit perturb,
                         output int done_cyc);
    logic [1:0]    act, g;
    logic          win, is_wr, ok;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er;
    int            c0, exp_lat;
    bit            seen, got;
    act     = rd | wr;
    win     = (act == 2'b11) ? ~m_last : act[1];
    g       = win ? 2'b10 : 2'b01;
    is_wr   = wr[win];
    ea      = win ? m_a1 : m_a0;
    ed      = win ? m_d1 : m_d0;
    ok      = (xdelay >= 0) && (xdelay < int'(TMO));
    er      = (!is_wr && ok) ? rdv : '0;
    exp_lat = ok ? 4 + xdelay : 3 + int'(TMO);
    iss_q.push_back({is_wr, ~is_wr, is_wr, g, ea, ed});
    exp_q.push_back({~is_wr, g, ~ok, er});
    req_addr0  = m_a0;
    req_addr1  = m_a1;
    req_wdata0 = m_d0;
    req_wdata1 = m_d1;
    req_rd     = rd;
    req_wr     = wr;
    c0         = cyc;
    done_cyc   = -1;
    seen       = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge Clk);
      seen = read_request | write_request;
    end
    if (!seen) check_eq("issue_wait", {write_request, read_request}, {is_wr, ~is_wr});
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(posedge Clk);
      #1;
      xfer_done = (k == xdelay);
      read_data = rdv;
      if (perturb && k == 0) begin
        req_rd     = 2'b00;
        req_wr     = 2'b00;
        req_addr0  = ~m_a0;
        req_addr1  = ~m_a1;
        req_wdata0 = ~m_d0;
        req_wdata1 = ~m_d1;
      end
      @(negedge Clk);
      if (done != 2'b00) begin
        got      = 1'b1;
        done_cyc = cyc;
        check_eq("latency", cyc - c0 + 1, exp_lat);
      end
    end
    if (!got) check_eq("done_wait", done, g);
    @(posedge Clk);
    #1;
    xfer_done = 1'b0;
    if (!hold) begin
      req_rd = 2'b00;
      req_wr = 2'b00;
    end
    m_last = win;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int            dc, prev, xd;
    logic [1:0]    rr, ww;
    bit            seen;
    reset      = 1'b1;
    req_rd     = 2'b00;
    req_wr     = 2'b00;
    req_addr0  = '0;
    req_addr1  = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
    read_data  = '0;
    xfer_done  = 1'b0;
    m_last     = 1'b1;
    m_a0 = '0; m_a1 = '0; m_d0 = '0; m_d1 = '0;
    prev = 0;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_eq("rst_state", o_dbg_state, 2'd0);
    check_eq("rst_gnt",   gnt,         2'b00);
    check_eq("rst_done",  done,        2'b00);
    check_eq("rst_err",   err,         1'b0);
    check_eq("rst_dv",    data_valid,  1'b0);
    check_eq("rst_rreq",  read_request, 1'b0);
    check_eq("rst_wreq",  write_request, 1'b0);
    check_eq("rst_addr",  address,     64'h0);
    check_eq("rst_wdata", write_data,  8'h00);
    check_eq("rst_rdata", rdata,       8'h00);
    @(posedge Clk);
    #1;
    reset = 1'b0;

    // single read, immediate completion
    m_a0 = 64'h10; m_a1 = 64'h7777; m_d0 = 8'h00; m_d1 = 8'h00;
    run_txn(2'b01, 2'b00, 0, 8'hA5, 0, 0, dc);

    // rd+wr on requester 1 is a write
    m_a1 = 64'h2000; m_d1 = 8'h3C;
    run_txn(2'b10, 2'b10, 0, 8'h00, 0, 0, dc);

    // contention: both writing continuously, grants alternate, one per 4 cycles
    m_a0 = 64'hA0A0; m_a1 = 64'hB0B0; m_d0 = 8'hA1; m_d1 = 8'hB2;
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b00, 2'b11, 0, 8'h00, (i < 3), 0, dc);
      if (i > 0) check_eq("b2b_gap", dc - prev, 4);
      prev = dc;
    end

    // timeout, then a normal transaction
    m_a1 = 64'h1234_5678_9ABC_DEF0;
    run_txn(2'b10, 2'b00, -1, 8'h77, 0, 0, dc);
    run_txn(2'b01, 2'b00, 1, 8'h5A, 0, 0, dc);

    // xfer_done on the timeout cycle wins
    run_txn(2'b01, 2'b00, int'(TMO) - 1, 8'hC3, 0, 0, dc);

    // xfer_done arriving in RESP is ignored; transaction already timed out
    run_txn(2'b10, 2'b00, int'(TMO), 8'h99, 0, 0, dc);

    // request inputs changing mid-flight do not disturb the transaction
    m_a0 = 64'hFACE_0000_0000_0042;
    run_txn(2'b01, 2'b00, 2, 8'h6E, 0, 1, dc);

    // reset during WAIT aborts silently; a late xfer_done is ignored
    m_a1 = 64'hDEAD_BEEF_0000_0001; m_d1 = 8'h5F;
    req_addr1  = m_a1;
    req_wdata1 = m_d1;
    iss_q.push_back({1'b0, 1'b1, 1'b0, 2'b10, m_a1, m_d1});
    req_rd = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge Clk);
      seen = read_request;
    end
    if (!seen) check_eq("rstw_issue", read_request, 1'b1);
    @(posedge Clk);
    #1;
    reset = 1'b1;
    @(posedge Clk);
    #1;
    reset     = 1'b0;
    req_rd    = 2'b00;
    xfer_done = 1'b1;
    read_data = 8'hEE;
    @(posedge Clk);
    #1;
    xfer_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      check_eq("rstw_gnt",  gnt,  2'b00);
      check_eq("rstw_done", done, 2'b00);
      check_eq("rstw_err",  err,  1'b0);
    end
    check_eq("rstw_state", o_dbg_state, 2'd0);
    check_eq("rstw_rdata", rdata, 8'h00);
    m_last = 1'b1;
    @(posedge Clk);
    #1;
    run_txn(2'b11, 2'b00, 0, 8'h42, 0, 0, dc);

    // random mix
    for (int i = 0; i < 12; i++) begin
      rr = 2'($urandom_range(0, 3));
      ww = 2'($urandom_range(0, 3));
      if ((rr | ww) == 2'b00) rr = 2'b01;
      m_a0 = {$urandom(), $urandom()};
      m_a1 = {$urandom(), $urandom()};
      m_d0 = 8'($urandom_range(0, 255));
      m_d1 = 8'($urandom_range(0, 255));
      xd   = $urandom_range(0, 5);
      run_txn(rr, ww, xd, 8'($urandom_range(0, 255)), 0, 0, dc);
    end

    repeat (2) @(negedge Clk);
    check_eq("iss_left", iss_q.size(), 0);
    check_eq("exp_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
